// File: rtl/sr_bank_pkg.sv
// rtl/sr_bank_pkg.sv - conflict-mode constants and per-cell next-state function
package sr_bank_pkg;

   localparam int MODE_HOLD    = 0;
   localparam int MODE_SET_DOM = 1;
   localparam int MODE_RST_DOM = 2;
   localparam int MODE_TOGGLE  = 3;

   function automatic logic sr_next(input logic q_cur, input logic ss, input logic rs,
                                    input int mode);
      logic nxt;
      nxt = q_cur;
      case ({ss, rs})
         2'b10: nxt = 1'b1;
         2'b01: nxt = 1'b0;
         2'b11: begin
            case (mode)
               MODE_SET_DOM: nxt = 1'b1;
               MODE_RST_DOM: nxt = 1'b0;
               MODE_TOGGLE:  nxt = ~q_cur;
               default:      nxt = q_cur;
            endcase
         end
         default: nxt = q_cur;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/sr_sync.sv
// rtl/sr_sync.sv - STAGES-deep single-bit synchroniser with synchronous reset
module sr_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   if (STAGES == 0) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = clk ^ rst;
      assign dout = din;
   end else begin : g_chain
      logic [STAGES-1:0] chain_q;
      logic [STAGES-1:0] chain_d;

      always_comb begin
         chain_d    = chain_q << 1;
         chain_d[0] = din;
      end

      always_ff @(posedge clk) begin
         if (rst) chain_q <= '0;
         else     chain_q <= chain_d;
      end

      assign dout = chain_q[STAGES-1];
   end

endmodule

// File: rtl/sr_flop_bank.sv
// rtl/sr_flop_bank.sv - bank of synchronous SR cells with conflict reporting and counter
module sr_flop_bank
   import sr_bank_pkg::*;
#(
   parameter int                  CHANNELS    = 4,
   parameter int                  MODE        = MODE_HOLD,
   parameter int                  SYNC_STAGES = 2,
   parameter logic [CHANNELS-1:0] RESET_VALUE = {CHANNELS{1'b0}},
   parameter int                  CNT_W       = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] s,
   input  logic [CHANNELS-1:0] r,
   input  logic                en,
   input  logic                cnt_clr,
   output logic [CHANNELS-1:0] q,
   output logic [CHANNELS-1:0] qn,
   output logic [CHANNELS-1:0] changed,
   output logic [CHANNELS-1:0] conflict,
   output logic [CNT_W-1:0]    conflict_count
);

   if (MODE < MODE_HOLD || MODE > MODE_TOGGLE) begin : g_bad_mode
      $error("sr_flop_bank: MODE must be 0..3");
   end
   if (CHANNELS < 1 || CNT_W < 1 || SYNC_STAGES < 0) begin : g_bad_size
      $error("sr_flop_bank: CHANNELS and CNT_W must be >= 1, SYNC_STAGES >= 0");
   end

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CHANNELS-1:0] ss, rs, cell_nxt;
   logic [CHANNELS-1:0] q_q, q_d, qn_q, qn_d;
   logic [CHANNELS-1:0] changed_q, changed_d, conflict_q, conflict_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      sr_sync #(.STAGES(SYNC_STAGES)) u_sync_s (.clk(clk), .rst(rst), .din(s[i]), .dout(ss[i]));
      sr_sync #(.STAGES(SYNC_STAGES)) u_sync_r (.clk(clk), .rst(rst), .din(r[i]), .dout(rs[i]));
      assign cell_nxt[i] = sr_next(q_q[i], ss[i], rs[i], MODE);
   end

   // en only gates the cells; the synchronisers above keep shifting regardless
   always_comb begin
      q_d        = q_q;
      changed_d  = '0;
      conflict_d = '0;
      cnt_d      = cnt_q;
      if (en) begin
         q_d        = cell_nxt;
         changed_d  = cell_nxt ^ q_q;
         conflict_d = ss & rs;
      end
      qn_d = ~q_d;
      if (cnt_clr)
         cnt_d = '0;
      else if ((|conflict_d) && (cnt_q != CNT_MAX))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q        <= RESET_VALUE;
         qn_q       <= ~RESET_VALUE;
         changed_q  <= '0;
         conflict_q <= '0;
         cnt_q      <= '0;
      end else begin
         q_q        <= q_d;
         qn_q       <= qn_d;
         changed_q  <= changed_d;
         conflict_q <= conflict_d;
         cnt_q      <= cnt_d;
      end
   end

   assign q              = q_q;
   assign qn             = qn_q;
   assign changed        = changed_q;
   assign conflict       = conflict_q;
   assign conflict_count = cnt_q;

endmodule
